// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings and lane helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_ERR_OK       = 2'b00;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] c_ERR_MISALIGN = 2'b10;
    localparam logic [1:0] c_ERR_FAULT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   byte_enable = 4'b0001 << addr_lo;
            2'b01:   byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   replicate = {4{wdata[7:0]}};
            2'b01:   replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts and sign/zero-extends a load field from a memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] w_field;

    assign w_field = word >> {addr_lo, 3'b000};

    always_comb begin
        result = '0;
        case (funct3)
            c_F3_B:  result = {{24{w_field[7]}}, w_field[7:0]};
            c_F3_H:  result = {{16{w_field[15]}}, w_field[15:0]};
            c_F3_W:  result = w_field;
            c_F3_BU: result = {24'd0, w_field[7:0]};
            c_F3_HU: result = {16'd0, w_field[15:0]};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store front end for a word-organised memory.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 256
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Address,
    input  logic [31:0] Req_Wdata,
    output logic        Rsp_Valid,
    output logic [31:0] Rsp_Rdata,
    output logic [1:0]  Rsp_Error,
    output logic        Mem_Read_Ctrl,
    output logic [3:0]  Mem_Write_Ctrl,
    output logic [31:0] Mem_Data_Address,
    output logic [31:0] Mem_Data_Write,
    input  logic [31:0] Mem_Data_Read
);

    lsu_state_e  r_state, w_next_state;
    logic [31:0] r_addr, r_wdata, r_rsp_rdata, w_load_data;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [1:0]  r_rsp_error, w_req_err;
    logic        w_illegal, w_misalign, w_fault, w_accept, w_issue;

    assign w_accept = (r_state == ST_IDLE) && Req_Valid;
    assign w_issue  = (r_state == ST_ISSUE);

    always_comb begin
        w_illegal = Req_Write ? (Req_Funct3 >= 3'b011)
                              : ((Req_Funct3 == 3'b011) || (Req_Funct3[2:1] == 2'b11));
        case (Req_Funct3[1:0])
            2'b01:   w_misalign = Req_Address[0];
            2'b10:   w_misalign = (Req_Address[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        w_fault = ({2'b00, Req_Address[31:2]} >= 32'(MEM_SIZE));
        if (w_illegal)       w_req_err = c_ERR_ILLEGAL;
        else if (w_misalign) w_req_err = c_ERR_MISALIGN;
        else if (w_fault)    w_req_err = c_ERR_FAULT;
        else                 w_req_err = c_ERR_OK;
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) r_state <= ST_IDLE;
        else             r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (Req_Valid) w_next_state = (w_req_err != c_ERR_OK) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next_state = r_write ? ST_RESP : ST_WAIT;
            ST_WAIT:  w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .word    (Mem_Data_Read),
        .addr_lo (r_addr[1:0]),
        .funct3  (r_funct3),
        .result  (w_load_data)
    );

    // Response registers only change on entry to RESP, so they hold between responses
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_write     <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= c_ERR_OK;
        end else begin
            if (w_accept) begin
                r_addr   <= Req_Address;
                r_wdata  <= Req_Wdata;
                r_funct3 <= Req_Funct3;
                r_write  <= Req_Write;
            end
            if (w_next_state == ST_RESP) begin
                r_rsp_error <= (r_state == ST_IDLE) ? w_req_err : c_ERR_OK;
                r_rsp_rdata <= (r_state == ST_WAIT) ? w_load_data : '0;
            end
        end
    end

    assign Req_Ready        = (r_state == ST_IDLE);
    assign Rsp_Valid        = (r_state == ST_RESP);
    assign Rsp_Rdata        = r_rsp_rdata;
    assign Rsp_Error        = r_rsp_error;
    assign Mem_Read_Ctrl    = w_issue && !r_write;
    assign Mem_Write_Ctrl   = (w_issue && r_write) ? byte_enable(r_funct3[1:0], r_addr[1:0]) : 4'b0000;
    assign Mem_Data_Address = w_issue ? {r_addr[31:2], 2'b00} : '0;
    assign Mem_Data_Write   = (w_issue && r_write) ? replicate(r_funct3[1:0], r_wdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a byte-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_SIZE = 256;
    localparam int AW       = $clog2(MEM_SIZE);

    logic        Clk_Core, Rst_Core_N;
    logic        Req_Valid, Req_Ready, Req_Write;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_Address, Req_Wdata;
    logic        Rsp_Valid;
    logic [31:0] Rsp_Rdata;
    logic [1:0]  Rsp_Error;
    logic        Mem_Read_Ctrl;
    logic [3:0]  Mem_Write_Ctrl;
    logic [31:0] Mem_Data_Address, Mem_Data_Write, Mem_Data_Read;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .Clk_Core         (Clk_Core),
        .Rst_Core_N       (Rst_Core_N),
        .Req_Valid        (Req_Valid),
        .Req_Ready        (Req_Ready),
        .Req_Write        (Req_Write),
        .Req_Funct3       (Req_Funct3),
        .Req_Address      (Req_Address),
        .Req_Wdata        (Req_Wdata),
        .Rsp_Valid        (Rsp_Valid),
        .Rsp_Rdata        (Rsp_Rdata),
        .Rsp_Error        (Rsp_Error),
        .Mem_Read_Ctrl    (Mem_Read_Ctrl),
        .Mem_Write_Ctrl   (Mem_Write_Ctrl),
        .Mem_Data_Address (Mem_Data_Address),
        .Mem_Data_Write   (Mem_Data_Write),
        .Mem_Data_Read    (Mem_Data_Read)
    );

    typedef struct { logic [31:0] rdata; logic [1:0] err; int cyc; } rsp_t;
    typedef struct { logic rd; logic [3:0] we; logic [31:0] addr; logic [31:0] data; int cyc; } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    rsp_t mon_r;
    mem_t mon_m;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic mem_clear;
    logic [31:0] mem [0:MEM_SIZE-1];
    logic [7:0]  ref_bytes [0:MEM_SIZE*4-1];

    initial Clk_Core = 1'b0;
    always #5 Clk_Core = ~Clk_Core;
    always @(posedge Clk_Core) cyc <= cyc + 1;

    // Memory instance: registered read, byte-lane writes
    always @(posedge Clk_Core) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
        end else begin
            if (Mem_Read_Ctrl) Mem_Data_Read <= mem[Mem_Data_Address[AW+1:2]];
            for (int i = 0; i < 4; i++)
                if (Mem_Write_Ctrl[i]) mem[Mem_Data_Address[AW+1:2]][8*i +: 8] <= Mem_Data_Write[8*i +: 8];
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response or memory access
    always @(negedge Clk_Core) begin
        if (Rst_Core_N) begin
            if (Rsp_Valid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rsp_unexpected: got response err=%0d expected none", Rsp_Error);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_rdata", Rsp_Rdata, mon_r.rdata);
                    check("rsp_error", 32'(Rsp_Error), 32'(mon_r.err));
                    check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
                end
            end
            if (Mem_Read_Ctrl || (Mem_Write_Ctrl != 4'b0000)) begin
                if (mem_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_unexpected: got rd=%0b we=%04b expected no access", Mem_Read_Ctrl, Mem_Write_Ctrl);
                end else begin
                    mon_m = mem_q.pop_front();
                    check("mem_read", 32'(Mem_Read_Ctrl), 32'(mon_m.rd));
                    check("mem_we", 32'(Mem_Write_Ctrl), 32'(mon_m.we));
                    check("mem_addr", Mem_Data_Address, mon_m.addr);
                    check("mem_wdata", Mem_Data_Write, mon_m.data);
                    check("mem_cycle", 32'(cyc), 32'(mon_m.cyc));
                end
            end else begin
                check("mem_idle", Mem_Data_Address | Mem_Data_Write, 32'h0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(Req_Ready), 32'h1);
        check({tag, "_rsp_valid"}, 32'(Rsp_Valid), 32'h0);
        check({tag, "_rsp_rdata"}, Rsp_Rdata, 32'h0);
        check({tag, "_rsp_error"}, 32'(Rsp_Error), 32'h0);
        check({tag, "_mem_ctrl"}, {27'd0, Mem_Read_Ctrl, Mem_Write_Ctrl}, 32'h0);
        check({tag, "_mem_bus"}, Mem_Data_Address | Mem_Data_Write, 32'h0);
    endtask

    // Issues one request; the reference model derives error, memory traffic and load data
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit abort);
        int guard = 0;
        int sz, off;
        logic [1:0]  err;
        logic [31:0] val;
        rsp_t r;
        mem_t m;
        @(negedge Clk_Core);
        while (Req_Ready !== 1'b1 && guard < 40) begin
            Req_Valid   = 1'($urandom_range(0, 1));
            Req_Write   = 1'($urandom_range(0, 1));
            Req_Funct3  = 3'($urandom);
            Req_Address = $urandom;
            Req_Wdata   = $urandom;
            @(negedge Clk_Core);
            guard++;
        end
        if (guard >= 40) begin
            n_checks++; n_errors++;
            $display("FAIL ready_timeout: got Req_Ready=0 for 40 cycles expected 1");
            Req_Valid = 1'b0;
            return;
        end
        Req_Valid = 1'b1; Req_Write = wr; Req_Funct3 = f3; Req_Address = addr; Req_Wdata = wd;

        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(addr % 4);
        if (wr ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6)) err = 2'b01;
        else if ((addr % sz) != 0)                          err = 2'b10;
        else if ((addr >> 2) >= MEM_SIZE)                   err = 2'b11;
        else                                                err = 2'b00;

        val = '0;
        if (err == 2'b00) begin
            m.cyc  = cyc + 1;
            m.addr = addr & ~32'h3;
            m.we   = 4'b0000;
            m.data = '0;
            m.rd   = !wr;
            if (wr) begin
                for (int i = 0; i < sz; i++) m.we[off + i] = 1'b1;
                for (int lane = 0; lane < 4; lane++) m.data[8*lane +: 8] = wd[8*(lane % sz) +: 8];
                if (!abort)
                    for (int i = 0; i < sz; i++) ref_bytes[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) val[8*i +: 8] = ref_bytes[int'(addr) + i];
                if (!f3[2] && sz < 4 && val[8*sz - 1]) val = val | ~((32'h1 << (8*sz)) - 32'h1);
            end
            mem_q.push_back(m);
        end
        if (!abort) begin
            r.rdata = val;
            r.err   = err;
            r.cyc   = cyc + 1 + ((err != 2'b00) ? 0 : (wr ? 1 : 2));
            rsp_q.push_back(r);
        end
        @(negedge Clk_Core);
        Req_Valid = 1'b0;
        if (abort) begin
            #2 Rst_Core_N = 1'b0;
            #1 check_reset_outputs("abort");
            @(negedge Clk_Core);
            Rst_Core_N = 1'b1;
        end
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

        Rst_Core_N = 1'b0; mem_clear = 1'b1;
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Funct3 = '0; Req_Address = '0; Req_Wdata = '0;
        for (int i = 0; i < MEM_SIZE*4; i++) ref_bytes[i] = 8'h00;
        repeat (3) @(negedge Clk_Core);
        check_reset_outputs("reset");
        mem_clear  = 1'b0;
        Rst_Core_N = 1'b1;

        issue(1'b1, 3'b000, 32'h05, 32'h123456AB, 1'b0);
        issue(1'b0, 3'b000, 32'h05, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h05, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h06, 32'h0000BEEF, 1'b0);
        issue(1'b0, 3'b001, 32'h06, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h06, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h02, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b0);
        issue(1'b1, 3'b011, 32'h08, 32'h55AA55AA, 1'b0);
        issue(1'b0, 3'b010, 32'h04, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'h3FF, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                addr = 32'($urandom_range(0, MEM_SIZE*4 - 1));
                if ($urandom_range(0, 3) != 0)
                    addr = addr & ~((f3[1:0] == 2'b00) ? 32'h0 : (f3[1:0] == 2'b01) ? 32'h1 : 32'h3);
            end else begin
                addr = $urandom;
            end
            issue(wr, f3, addr, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge Clk_Core);
        end

        for (int g = 0; g < 20 && (rsp_q.size() != 0 || mem_q.size() != 0); g++) @(negedge Clk_Core);
        if (rsp_q.size() != 0 || mem_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got %0d responses and %0d accesses outstanding expected 0",
                     rsp_q.size(), mem_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
